// File: rtl/controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : controller_sequencer
// Purpose  : T1-T6 ring counter and opcode decode producing every bus strobe
//            of the 8-bit bus CPU. Optional macro STEP_EN adds a single-step
//            enable that gates ring advance and all strobes except hlt.
// Revision : 1.0  initial release
// ============================================================================
module controller_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
`ifdef STEP_EN
  input  logic       step,
`endif
  output logic [5:0] t,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       hlt
);

  localparam logic [3:0] C_OP_LDA = 4'h0;
  localparam logic [3:0] C_OP_ADD = 4'h1;
  localparam logic [3:0] C_OP_SUB = 4'h2;
  localparam logic [3:0] C_OP_OUT = 4'hE;
  localparam logic [3:0] C_OP_HLT = 4'hF;

  logic [5:0] r_t;
  logic       r_halted;
  logic       w_adv;
  logic       w_en;
  logic       w_hlt_t4;
  logic       w_cp, w_ep, w_lm, w_ce, w_li, w_ei;
  logic       w_la, w_ea, w_su, w_eu, w_lb, w_lo;

`ifdef STEP_EN
  assign w_adv = step;
`else
  assign w_adv = 1'b1;
`endif

  assign w_hlt_t4 = r_t[3] && (opcode == C_OP_HLT);

  // The halt opcode parks the ring at T4 instead of walking on to T5.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t      <= 6'b000001;
      r_halted <= 1'b0;
    end else if (!r_halted && w_adv) begin
      if (w_hlt_t4) begin
        r_halted <= 1'b1;
      end else begin
        r_t <= {r_t[4:0], r_t[5]};
      end
    end
  end

  always_comb begin
    w_cp = 1'b0; w_ep = 1'b0; w_lm = 1'b0; w_ce = 1'b0; w_li = 1'b0; w_ei = 1'b0;
    w_la = 1'b0; w_ea = 1'b0; w_su = 1'b0; w_eu = 1'b0; w_lb = 1'b0; w_lo = 1'b0;
    unique case (1'b1)
      r_t[0]: begin w_ep = 1'b1; w_lm = 1'b1; end
      r_t[1]: w_cp = 1'b1;
      r_t[2]: begin w_ce = 1'b1; w_li = 1'b1; end
      r_t[3]: begin
        case (opcode)
          C_OP_LDA, C_OP_ADD, C_OP_SUB: begin w_ei = 1'b1; w_lm = 1'b1; end
          C_OP_OUT:                     begin w_ea = 1'b1; w_lo = 1'b1; end
          default: ;
        endcase
      end
      r_t[4]: begin
        case (opcode)
          C_OP_LDA:           begin w_ce = 1'b1; w_la = 1'b1; end
          C_OP_ADD, C_OP_SUB: begin w_ce = 1'b1; w_lb = 1'b1; end
          default: ;
        endcase
      end
      r_t[5]: begin
        case (opcode)
          C_OP_ADD: begin w_eu = 1'b1; w_la = 1'b1; end
          C_OP_SUB: begin w_su = 1'b1; w_eu = 1'b1; w_la = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Strobes last one enabled cycle and vanish during reset or halt.
  assign w_en = w_adv && !rst && !r_halted;

  assign t   = r_t;
  assign cp  = w_cp & w_en;
  assign ep  = w_ep & w_en;
  assign lm  = w_lm & w_en;
  assign ce  = w_ce & w_en;
  assign li  = w_li & w_en;
  assign ei  = w_ei & w_en;
  assign la  = w_la & w_en;
  assign ea  = w_ea & w_en;
  assign su  = w_su & w_en;
  assign eu  = w_eu & w_en;
  assign lb  = w_lb & w_en;
  assign lo  = w_lo & w_en;
  assign hlt = !rst && (r_halted || w_hlt_t4);

endmodule
`default_nettype wire

// File: tb/tb_controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller_sequencer
// Purpose  : Directed self-checking bench for controller_sequencer; the
//            STEP_EN macro enables the single-step checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_controller_sequencer;

  localparam logic [12:0] C_CP  = 13'h1000;
  localparam logic [12:0] C_EP  = 13'h0800;
  localparam logic [12:0] C_LM  = 13'h0400;
  localparam logic [12:0] C_CE  = 13'h0200;
  localparam logic [12:0] C_LI  = 13'h0100;
  localparam logic [12:0] C_EI  = 13'h0080;
  localparam logic [12:0] C_LA  = 13'h0040;
  localparam logic [12:0] C_EA  = 13'h0020;
  localparam logic [12:0] C_SU  = 13'h0010;
  localparam logic [12:0] C_EU  = 13'h0008;
  localparam logic [12:0] C_LB  = 13'h0004;
  localparam logic [12:0] C_LO  = 13'h0002;
  localparam logic [12:0] C_HLT = 13'h0001;
  localparam logic [12:0] C_NONE = 13'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic        step;
  logic [5:0]  t;
  logic        cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic [12:0] w_ctl;
  int          n_tests = 0;
  int          n_fail  = 0;

  assign w_ctl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};

  always #5 clk = ~clk;

  controller_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
`ifdef STEP_EN
    .step   (step),
`endif
    .t      (t),
    .cp     (cp),
    .ep     (ep),
    .lm     (lm),
    .ce     (ce),
    .li     (li),
    .ei     (ei),
    .la     (la),
    .ea     (ea),
    .su     (su),
    .eu     (eu),
    .lb     (lb),
    .lo     (lo),
    .hlt    (hlt)
  );

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks ring position, strobes and the one-bus-driver invariant together.
  task automatic chk_state(input string tag, input logic [5:0] exp_t, input logic [12:0] exp_ctl);
    chk({tag, ".t"}, {7'd0, t}, {7'd0, exp_t});
    chk({tag, ".ctl"}, w_ctl, exp_ctl);
    chk({tag, ".drv"}, 13'(($countones({ep, ce, ei, ea, eu}) <= 1)), 13'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at T1 (#1 after an edge); leaves the ring at the next T1.
  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [12:0] e4, input logic [12:0] e5, input logic [12:0] e6);
    opcode = ~op;
    #1;
    chk_state({tag, ".T1"}, 6'b000001, C_EP | C_LM);
    tick();
    chk_state({tag, ".T2"}, 6'b000010, C_CP);
    tick();
    chk_state({tag, ".T3"}, 6'b000100, C_CE | C_LI);
    opcode = op;
    tick();
    chk_state({tag, ".T4"}, 6'b001000, e4);
    tick();
    chk_state({tag, ".T5"}, 6'b010000, e5);
    tick();
    chk_state({tag, ".T6"}, 6'b100000, e6);
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 4'h0;
    step   = 1'b1;
    tick();
    tick();
    chk_state("reset_hold", 6'b000001, C_NONE);
    rst = 1'b0;
    #1;
    chk_state("reset_release", 6'b000001, C_EP | C_LM);

    run_instr("lda", 4'h0, C_EI | C_LM, C_CE | C_LA, C_NONE);
    run_instr("add", 4'h1, C_EI | C_LM, C_CE | C_LB, C_EU | C_LA);
    run_instr("sub", 4'h2, C_EI | C_LM, C_CE | C_LB, C_SU | C_EU | C_LA);
    run_instr("out", 4'hE, C_EA | C_LO, C_NONE, C_NONE);
    run_instr("nop", 4'h7, C_NONE, C_NONE, C_NONE);

    // Reset landing in T5 of an ADD.
    opcode = 4'h1;
    tick(); tick(); tick(); tick();
    chk_state("midrst.T5", 6'b010000, C_CE | C_LB);
    rst = 1'b1;
    #1;
    chk_state("midrst.forced", 6'b010000, C_NONE);
    tick();
    chk_state("midrst.after", 6'b000001, C_NONE);
    rst = 1'b0;
    #1;
    chk_state("midrst.T1", 6'b000001, C_EP | C_LM);
    tick();
    chk_state("midrst.T2", 6'b000010, C_CP);
    tick();
    chk_state("midrst.T3", 6'b000100, C_CE | C_LI);
    tick();

    // Halt: parks at T4 until reset.
    opcode = 4'hF;
    tick(); tick(); tick();
    chk_state("hlt.T4", 6'b001000, C_HLT);
    for (int i = 0; i < 22; i++) begin
      tick();
      chk_state($sformatf("hlt.frozen%0d", i), 6'b001000, C_HLT);
    end
    opcode = 4'h0;
    #1;
    chk_state("hlt.op_change", 6'b001000, C_HLT);
    rst = 1'b1;
    #1;
    chk_state("hlt.rst_forced", 6'b001000, C_NONE);
    tick();
    rst = 1'b0;
    #1;
    chk_state("hlt.restart", 6'b000001, C_EP | C_LM);
    run_instr("lda2", 4'h0, C_EI | C_LM, C_CE | C_LA, C_NONE);

`ifdef STEP_EN
    tick();
    chk_state("step.T2", 6'b000010, C_CP);
    step = 1'b0;
    #1;
    chk_state("step.gated", 6'b000010, C_NONE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_state($sformatf("step.wait%0d", i), 6'b000010, C_NONE);
    end
    step = 1'b1;
    #1;
    chk_state("step.pulse", 6'b000010, C_CP);
    tick();
    step = 1'b0;
    #1;
    chk_state("step.T3", 6'b000100, C_NONE);
    step = 1'b1;
    #1;
    chk_state("step.T3en", 6'b000100, C_CE | C_LI);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
